// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, defaults and the sample-counter width helper.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    function automatic int cnt_width(input int os);
        return (os > 1) ? $clog2(os) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_sample_counter.sv
// tx_sample_counter: oversample tick counter; wrap marks the end of a bit period.
module tx_sample_counter import uart_pkg::*; #(
    parameter  int OVERSAMPLE = OVERSAMPLE_DEF,
    localparam int CW         = cnt_width(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          tick,
    output logic [CW-1:0] count,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] count_q, count_d;

    assign wrap  = tick && count_q == LAST;
    assign count = count_q;

    // clear wins over tick so a tick on the accepting edge is not counted
    always_comb count_d = clear ? '0 : wrap ? '0 : tick ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) count_q <= '0;
        else      count_q <= count_d;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: LSB-first 8N1-style serial transmitter timed by a shared oversample tick.
module uart_tx import uart_pkg::*; #(
    parameter  int DATA_BITS  = DATA_BITS_DEF,
    parameter  int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter  int STOP_BITS  = 1,
    localparam int CW         = cnt_width(OVERSAMPLE),
    localparam int BW         = $clog2(DATA_BITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic [CW-1:0]        count;
    logic                 wrap;

    tx_sample_counter #(.OVERSAMPLE(OVERSAMPLE)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == IDLE),
        .tick  (tick),
        .count (count),
        .wrap  (wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = start ? START : IDLE;
            START: state_d = wrap ? DATA : START;
            DATA:  state_d = (wrap && bit_q == LAST_BIT) ? STOP : DATA;
            STOP:  state_d = (wrap && stop_q == LAST_STOP) ? IDLE : STOP;
        endcase
    end

    // the next line value is prepared one period ahead so tx stays a pure register
    always_comb begin
        shift_d = shift_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                shift_d = start ? data_in : shift_q;
                bit_d   = start ? '0 : bit_q;
                stop_d  = start ? 1'b0 : stop_q;
                tx_d    = !start;
                busy_d  = start;
            end
            START: tx_d = wrap ? shift_q[0] : tx_q;
            DATA: begin
                shift_d = wrap ? shift_q >> 1 : shift_q;
                bit_d   = wrap ? bit_q + 1'b1 : bit_q;
                tx_d    = !wrap ? tx_q : (bit_q == LAST_BIT) ? 1'b1 : shift_q[1];
            end
            STOP: begin
                stop_d = wrap ? stop_q + 1'b1 : stop_q;
                busy_d = !(wrap && stop_q == LAST_STOP);
                done_d = wrap && stop_q == LAST_STOP;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

    a_idle_count_clear: assert property (@(posedge clk) disable iff (!rst) state_q == IDLE |-> count == '0);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx (1 and 2 stop-bit builds).
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst, tick, start, sel;
    logic [7:0] data;
    logic       tx1, busy1, done1, tx2, busy2, done2;
    logic       tx_m, busy_m, done_m;
    int         n_cmp = 0, n_err = 0;
    int         tc = 0;
    int         bclks, lclks;

    always #5 clk = ~clk;

    uart_tx u_dut1 (
        .clk(clk), .rst(rst), .tick(tick), .start(start & ~sel), .data_in(data),
        .tx(tx1), .busy(busy1), .done(done1)
    );

    uart_tx #(.STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .tick(tick), .start(start & sel), .data_in(data),
        .tx(tx2), .busy(busy2), .done(done2)
    );

    assign tx_m   = sel ? tx2 : tx1;
    assign busy_m = sel ? busy2 : busy1;
    assign done_m = sel ? done2 : done1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int k);
        return (k == 0) ? 1'b0 : (k <= 8) ? d[k-1] : 1'b1;
    endfunction

    task automatic step(input int tdiv);
        tick = (tc % tdiv == 0);
        tc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            chk("idle_tx", tx_m, 1'b1);
            chk("idle_busy", busy_m, 1'b0);
            chk("idle_done", done_m, 1'b0);
        end
    endtask

    // tick-count model: the line level follows bit (ticks since accept)/16
    task automatic frame(input logic [7:0] d, input int sb, input int tdiv, input bit hold,
                         input int inj, output int busy_clks, output int low_clks);
        int total = (9 + sb) * 16;
        int tk = 0;
        int n = 0;
        start = 1'b1;
        data  = d;
        step(tdiv);
        if (!hold) start = 1'b0;
        busy_clks = 0;
        low_clks  = 0;
        while (tk < total) begin
            chk("frame_tx", tx_m, exp_bit(d, tk / 16));
            chk("frame_busy", busy_m, 1'b1);
            chk("frame_done", done_m, 1'b0);
            busy_clks += busy_m ? 1 : 0;
            low_clks  += tx_m ? 0 : 1;
            if (n == inj) begin
                start = 1'b1;
                data  = 8'hFF;
            end else if (!hold && n == inj + 1) begin
                start = 1'b0;
            end
            step(tdiv);
            if (tick) tk++;
            n++;
        end
        chk("end_done", done_m, 1'b1);
        chk("end_busy", busy_m, 1'b0);
        chk("end_tx", tx_m, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0; data = 8'h00; tick = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_tx", tx1, 1'b1);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_tx2", tx2, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        idle(5);

        frame(8'hA5, 1, 1, 1'b0, -1, bclks, lclks);
        chk("a5_busy_clks", bclks, 160);
        idle(3);

        tc = 0;
        frame(8'h00, 1, 4, 1'b0, -1, bclks, lclks);
        chk("sparse_low_clks", lclks, 576);
        chk("sparse_busy_clks", bclks, 640);
        idle(3);

        frame(8'h3C, 1, 1, 1'b0, 40, bclks, lclks);
        idle(20);

        frame(8'h55, 1, 1, 1'b1, -1, bclks, lclks);
        frame(8'hAA, 1, 1, 1'b1, -1, bclks, lclks);
        start = 1'b0;
        idle(20);

        start = 1'b1;
        data  = 8'hA5;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 40; i++) step(1);
        chk("mid_tx_low", tx1, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_tx", tx1, 1'b1);
        chk("mid_rst_busy", busy1, 1'b0);
        chk("mid_rst_done", done1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle(20);

        sel = 1'b1;
        idle(2);
        frame(8'h81, 2, 1, 1'b0, -1, bclks, lclks);
        chk("stop2_busy_clks", bclks, 176);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
